// File: rtl/booth_radix4_seq.sv
// Sequential radix-4 Booth multiplier: one Booth digit retired per clock.
// Build option BOOTH_ZERO_SKIP_EN ends CALC early when the remaining digits are all zero.
module booth_radix4_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int NDIG = WIDTH / 2 + 1;
  localparam int XW   = WIDTH + 2;
  localparam int PW   = 2 * WIDTH;
  localparam int CW   = $clog2(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] am_q, am_d;
  logic [XW:0]   bsh_q, bsh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] p_q, p_d;
  logic          done_q, done_d;

  logic [XW-1:0] ax, bx;
  logic [PW-1:0] term, sum;
  logic [XW:0]   bsh_nx;
  logic          last;

  // Operand extension to WIDTH+2 bits, sign or zero per mode.
  assign ax = {{2{signed_mode & a[WIDTH-1]}}, a};
  assign bx = {{2{signed_mode & b[WIDTH-1]}}, b};

  // Multiplier window after this digit; top bit replicates so
  // the "all bits equal" test stays valid once it runs dry.
  assign bsh_nx = {{2{bsh_q[XW]}}, bsh_q[XW:2]};

  // Booth digit decode; am_q already carries the 2i shift.
  // Bits above 2*WIDTH never reach p, so only 2*WIDTH are kept.
  always_comb begin
    term = '0;
    unique case (bsh_q[2:0])
      3'b000, 3'b111: term = '0;
      3'b001, 3'b010: term = am_q;
      3'b011:         term = am_q << 1;
      3'b100:         term = ~(am_q << 1) + ONE;
      3'b101, 3'b110: term = ~am_q + ONE;
    endcase
  end

  assign sum = acc_q + term;

`ifdef BOOTH_ZERO_SKIP_EN
  assign last = (cnt_q == LAST) | (&bsh_nx) | ~(|bsh_nx);
`else
  assign last = (cnt_q == LAST);
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    am_d    = am_q;
    bsh_d   = bsh_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = CALC;
          acc_d   = '0;
          cnt_d   = '0;
          am_d    = {{(PW-XW){ax[XW-1]}}, ax};
          bsh_d   = {bx, 1'b0};
        end
      end
      CALC: begin
        acc_d = sum;
        am_d  = am_q << 2;
        bsh_d = bsh_nx;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          p_d     = sum;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      am_q    <= '0;
      bsh_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      am_q    <= am_d;
      bsh_q   <= bsh_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q != CALC);
  assign done  = done_q;
  assign p     = p_q;

endmodule

// File: tb/tb_booth_radix4_seq.sv
// Randomised bench for booth_radix4_seq against plain integer multiply.
// Latency model follows BOOTH_ZERO_SKIP_EN when that macro is defined.
module tb_booth_radix4_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        ready;
  logic        done;
  logic [15:0] p;

  int checks = 0;
  int errors = 0;

  booth_radix4_seq #(.WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .signed_mode(signed_mode),
    .a(a),
    .b(b),
    .ready(ready),
    .done(done),
    .p(p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint ext(input bit sm, input logic [7:0] x);
    longint v;
    if (sm) v = longint'($signed(x));
    else v = longint'(x);
    return v;
  endfunction

  function automatic logic [15:0] ref_p(input bit sm, input logic [7:0] x,
                                        input logic [7:0] y);
    longint pr;
    pr = ext(sm, x) * ext(sm, y);
    return pr[15:0];
  endfunction

  function automatic int ref_lat(input bit sm, input logic [7:0] y);
    int lat;
    lat = 5;
`ifdef BOOTH_ZERO_SKIP_EN
    for (int i = 4; i >= 0; i--) begin
      longint r;
      r = ext(sm, y) >>> (2 * i + 1);
      if (r == 0 || r == -1) lat = i + 1;
    end
`else
    lat = 5 + 0 * int'(sm) + 0 * int'(y);
`endif
    return lat;
  endfunction

  task automatic launch(input bit sm, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    signed_mode = sm;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count negedges after the accepting edge until done; optional
  // stray start during CALC at negedge number glitch_at.
  task automatic wait_done(input int glitch_at, output int lat);
    int n;
    n = 0;
    lat = -1;
    while (lat < 0 && n <= 20) begin
      @(negedge clk);
      n++;
      if (glitch_at > 0 && n == glitch_at) begin
        a = 8'h11;
        b = 8'h22;
        signed_mode = 1'b0;
        start = 1'b1;
      end
      if (glitch_at > 0 && n == glitch_at + 1) start = 1'b0;
      if (done) begin
        lat = n - 1;
        chk("ready_done", ready, 1);
      end else begin
        chk("ready_calc", ready, 0);
      end
    end
    if (lat < 0) chk("timeout", 0, 1);
  endtask

  task automatic op(input bit sm, input logic [7:0] x, input logic [7:0] y);
    int lat;
    launch(sm, x, y);
    wait_done(0, lat);
    chk("p", p, ref_p(sm, x, y));
    chk("lat", lat, ref_lat(sm, y));
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  initial begin
    int lat;
    bit seen;
    #12;
    chk("rst_p", p, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    op(1, 8'h85, 8'h12);
    op(1, 8'hFF, 8'hFF);
    op(0, 8'hFF, 8'hFF);
    op(1, 8'h80, 8'h80);
    op(1, 8'h80, 8'h7F);
    op(0, 8'h80, 8'h7F);
    op(1, 8'h00, 8'h5A);
    op(0, 8'hA7, 8'h00);
    op(1, 8'h37, 8'h01);
    op(1, 8'h37, 8'h40);
    op(0, 8'hC3, 8'h01);

    launch(1, 8'h85, 8'h12);
    wait_done(2, lat);
    chk("ignored_p", p, 16'hF75A);
    chk("ignored_lat", lat, ref_lat(1, 8'h12));
    a = 8'h03;
    b = 8'h05;
    signed_mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(0, lat);
    chk("b2b_p", p, 16'h000F);
    chk("b2b_lat", lat, ref_lat(0, 8'h05));

    launch(0, 8'hFF, 8'hFF);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_p", p, 0);
    chk("arst_done", done, 0);
    chk("arst_ready", ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("arst_nodone", seen, 0);

    for (int i = 0; i < 6000; i++) begin
      op(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
